// File: rtl/pcileech_ft601_emu_if.sv
// FT601 245 synchronous FIFO pad bundle.
// slave  : the chip side (this emulator) - samples strobes, drives flags and read data.
// master : the com controller side - drives strobes and write data.
// Signals: ft601_data_in/out (32), ft601_data_oe, ft601_be_in/out (4),
//          ft601_rxf_n, ft601_txe_n, ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_siwu_n.
interface pcileech_ft601_emu_if;
  logic [31:0] ft601_data_in;
  logic [31:0] ft601_data_out;
  logic        ft601_data_oe;
  logic [3:0]  ft601_be_in;
  logic [3:0]  ft601_be_out;
  logic        ft601_rxf_n;
  logic        ft601_txe_n;
  logic        ft601_rd_n;
  logic        ft601_oe_n;
  logic        ft601_wr_n;
  logic        ft601_siwu_n;

  modport slave (
    input  ft601_data_in, ft601_be_in, ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_siwu_n,
    output ft601_data_out, ft601_data_oe, ft601_be_out, ft601_rxf_n, ft601_txe_n
  );

  modport master (
    output ft601_data_in, ft601_be_in, ft601_rd_n, ft601_oe_n, ft601_wr_n, ft601_siwu_n,
    input  ft601_data_out, ft601_data_oe, ft601_be_out, ft601_rxf_n, ft601_txe_n
  );
endinterface

// File: rtl/pcileech_ft601_emu.sv
// Device-side FT601 245 synchronous FIFO emulator.
// Ports:
//   ft601_clk, ft601_rst_n     : clock, async active-low reset
//   bus (slave modport)        : FT601 pads as seen by the com controller
//   host_din/valid/ready       : host push into the RX buffer (host -> master)
//   host_dout/valid/rd_en      : host pop from the TX buffer, FWFT, {be, data}
//   err_wr_ovf, err_rd_udf     : saturating protocol error counters
module pcileech_ft601_emu #(
  parameter int unsigned RX_DEPTH_LOG2 = 10,
  parameter int unsigned TX_DEPTH_LOG2 = 10,
  parameter int unsigned TX_MARGIN     = 4
) (
  input  logic                ft601_clk,
  input  logic                ft601_rst_n,
  pcileech_ft601_emu_if.slave bus,
  input  logic [31:0]         host_din,
  input  logic                host_din_valid,
  output logic                host_din_ready,
  output logic [35:0]         host_dout,
  output logic                host_dout_valid,
  input  logic                host_dout_rd_en,
  output logic [15:0]         err_wr_ovf,
  output logic [15:0]         err_rd_udf
);
  localparam int unsigned RX_DEPTH = 1 << RX_DEPTH_LOG2;
  localparam int unsigned TX_DEPTH = 1 << TX_DEPTH_LOG2;
  localparam logic [RX_DEPTH_LOG2:0] RX_FULL   = RX_DEPTH[RX_DEPTH_LOG2:0];
  localparam logic [TX_DEPTH_LOG2:0] TX_FULL   = TX_DEPTH[TX_DEPTH_LOG2:0];
  localparam logic [TX_DEPTH_LOG2:0] TX_THRESH = TX_FULL - TX_MARGIN[TX_DEPTH_LOG2:0];
  localparam logic [RX_DEPTH_LOG2:0] RX_ONE    = 1;
  localparam logic [TX_DEPTH_LOG2:0] TX_ONE    = 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'b001,
    S_RD   = 3'b010,
    S_WR   = 3'b100
  } state_t;

  state_t r_state, w_state_nxt;

  logic [31:0]              r_rx_mem [RX_DEPTH];
  logic [35:0]              r_tx_mem [TX_DEPTH];
  logic [RX_DEPTH_LOG2-1:0] r_rx_wptr, r_rx_rptr;
  logic [TX_DEPTH_LOG2-1:0] r_tx_wptr, r_tx_rptr;
  logic [RX_DEPTH_LOG2:0]   r_rx_cnt, w_rx_cnt_nxt;
  logic [TX_DEPTH_LOG2:0]   r_tx_cnt, w_tx_cnt_nxt;
  logic                     r_rxf_n, r_txe_n, r_data_oe;
  logic [15:0]              r_err_wr_ovf, r_err_rd_udf;

  logic w_oe, w_rd, w_wr;
  logic w_rd_req, w_rx_pop, w_rx_udf, w_rx_push;
  logic w_wr_viol, w_tx_try, w_tx_push, w_tx_pop, w_tx_ovf;
  logic w_unused;

  assign w_oe = ~bus.ft601_oe_n;
  assign w_rd = ~bus.ft601_rd_n;
  assign w_wr = ~bus.ft601_wr_n;
  assign w_unused = bus.ft601_siwu_n;

  // RX side: a read strobe is only honoured while the bus is not owned by a write.
  assign w_rd_req  = w_oe & w_rd & (r_state != S_WR);
  assign w_rx_pop  = w_rd_req & (r_rx_cnt != '0);
  assign w_rx_udf  = w_rd_req & (r_rx_cnt == '0);
  // A full buffer still accepts a push when the master drains a word in the same cycle.
  assign host_din_ready = (r_rx_cnt != RX_FULL) | w_rx_pop;
  assign w_rx_push = host_din_valid & host_din_ready;

  // TX side: a write strobe during a read turnaround is a violation, never stored.
  assign host_dout_valid = (r_tx_cnt != '0);
  assign w_tx_pop  = host_dout_rd_en & host_dout_valid;
  assign w_wr_viol = w_wr & (r_state == S_RD);
  assign w_tx_try  = w_wr & (r_state != S_RD);
  assign w_tx_push = w_tx_try & ((r_tx_cnt != TX_FULL) | w_tx_pop);
  assign w_tx_ovf  = w_wr_viol | (w_tx_try & ~w_tx_push);

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (w_oe)      w_state_nxt = S_RD;
        else if (w_wr) w_state_nxt = S_WR;
      end
      S_RD:    if (!w_oe) w_state_nxt = S_IDLE;
      S_WR:    if (!w_wr) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    w_rx_cnt_nxt = r_rx_cnt;
    if (w_rx_push && !w_rx_pop)      w_rx_cnt_nxt = r_rx_cnt + RX_ONE;
    else if (!w_rx_push && w_rx_pop) w_rx_cnt_nxt = r_rx_cnt - RX_ONE;
    w_tx_cnt_nxt = r_tx_cnt;
    if (w_tx_push && !w_tx_pop)      w_tx_cnt_nxt = r_tx_cnt + TX_ONE;
    else if (!w_tx_push && w_tx_pop) w_tx_cnt_nxt = r_tx_cnt - TX_ONE;
  end

  always_ff @(posedge ft601_clk) begin
    if (w_rx_push) r_rx_mem[r_rx_wptr] <= host_din;
    if (w_tx_push) r_tx_mem[r_tx_wptr] <= {bus.ft601_be_in, bus.ft601_data_in};
  end

  always_ff @(posedge ft601_clk or negedge ft601_rst_n) begin
    if (!ft601_rst_n) begin
      r_state      <= S_IDLE;
      r_rx_wptr    <= '0;
      r_rx_rptr    <= '0;
      r_tx_wptr    <= '0;
      r_tx_rptr    <= '0;
      r_rx_cnt     <= '0;
      r_tx_cnt     <= '0;
      r_rxf_n      <= 1'b1;
      r_txe_n      <= 1'b0;
      r_data_oe    <= 1'b0;
      r_err_wr_ovf <= '0;
      r_err_rd_udf <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_rx_cnt  <= w_rx_cnt_nxt;
      r_tx_cnt  <= w_tx_cnt_nxt;
      // Flags and bus enable are registered from next-state values so the
      // master sees them in the cycle right after the causing edge.
      r_rxf_n   <= (w_rx_cnt_nxt == '0);
      r_txe_n   <= (w_tx_cnt_nxt > TX_THRESH);
      r_data_oe <= (w_state_nxt == S_RD);
      if (w_rx_push) r_rx_wptr <= r_rx_wptr + 1'b1;
      if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + 1'b1;
      if (w_tx_push) r_tx_wptr <= r_tx_wptr + 1'b1;
      if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + 1'b1;
      if (w_tx_ovf && r_err_wr_ovf != '1) r_err_wr_ovf <= r_err_wr_ovf + 16'd1;
      if (w_rx_udf && r_err_rd_udf != '1) r_err_rd_udf <= r_err_rd_udf + 16'd1;
    end
  end

  assign bus.ft601_data_out = (r_rx_cnt == '0) ? '0 : r_rx_mem[r_rx_rptr];
  assign bus.ft601_data_oe  = r_data_oe;
  assign bus.ft601_be_out   = 4'hF;
  assign bus.ft601_rxf_n    = r_rxf_n;
  assign bus.ft601_txe_n    = r_txe_n;
  assign host_dout          = (r_tx_cnt == '0) ? '0 : r_tx_mem[r_tx_rptr];
  assign err_wr_ovf         = r_err_wr_ovf;
  assign err_rd_udf         = r_err_rd_udf;
endmodule

// File: tb/tb_pcileech_ft601_emu.sv
module tb_pcileech_ft601_emu;
  localparam int RXD = 8;   // RX_DEPTH_LOG2 = 3
  localparam int TXD = 16;  // TX_DEPTH_LOG2 = 4
  localparam int MARGIN = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] host_din = '0;
  logic        host_din_valid = 1'b0;
  logic        host_din_ready;
  logic [35:0] host_dout;
  logic        host_dout_valid;
  logic        host_dout_rd_en = 1'b0;
  logic [15:0] err_wr_ovf, err_rd_udf;

  pcileech_ft601_emu_if bus();

  pcileech_ft601_emu #(
    .RX_DEPTH_LOG2(3),
    .TX_DEPTH_LOG2(4),
    .TX_MARGIN(MARGIN)
  ) dut (
    .ft601_clk(clk),
    .ft601_rst_n(rst_n),
    .bus(bus),
    .host_din(host_din),
    .host_din_valid(host_din_valid),
    .host_din_ready(host_din_ready),
    .host_dout(host_dout),
    .host_dout_valid(host_dout_valid),
    .host_dout_rd_en(host_dout_rd_en),
    .err_wr_ovf(err_wr_ovf),
    .err_rd_udf(err_rd_udf)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  bit rnd_host = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: queues + bus ownership ----------------
  logic [31:0] rxq[$];
  logic [35:0] txq[$];
  int m_own;     // 0 free, 1 owned by read, 2 owned by write
  int m_ewr, m_erd;

  function automatic bit m_read_req();
    return !bus.ft601_oe_n && !bus.ft601_rd_n && m_own != 2;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rxq.delete(); txq.delete();
      m_own = 0; m_ewr = 0; m_erd = 0;
    end else begin
      bit req, rx_pop, rx_push, wr, viol, try_w, tx_pop, tx_push;
      req     = m_read_req();
      rx_pop  = req && rxq.size() > 0;
      rx_push = host_din_valid && (rxq.size() < RXD || rx_pop);
      wr      = !bus.ft601_wr_n;
      viol    = wr && m_own == 1;
      try_w   = wr && m_own != 1;
      tx_pop  = host_dout_rd_en && txq.size() > 0;
      tx_push = try_w && (txq.size() < TXD || tx_pop);
      if (req && rxq.size() == 0 && m_erd < 65535) m_erd++;
      if ((viol || (try_w && !tx_push)) && m_ewr < 65535) m_ewr++;
      if (rx_pop)  void'(rxq.pop_front());
      if (rx_push) rxq.push_back(host_din);
      if (tx_pop)  void'(txq.pop_front());
      if (tx_push) txq.push_back({bus.ft601_be_in, bus.ft601_data_in});
      if (m_own == 0)      m_own = !bus.ft601_oe_n ? 1 : (wr ? 2 : 0);
      else if (m_own == 1) m_own = !bus.ft601_oe_n ? 1 : 0;
      else                 m_own = wr ? 2 : 0;
    end
  end

  always @(negedge clk) begin
    bit ready;
    ready = rxq.size() < RXD || (m_read_req() && rxq.size() > 0);
    chk("rxf_n",      64'(bus.ft601_rxf_n),   64'(rxq.size() == 0));
    chk("txe_n",      64'(bus.ft601_txe_n),   64'((TXD - txq.size()) < MARGIN));
    chk("data_oe",    64'(bus.ft601_data_oe), 64'(m_own == 1));
    chk("data_out",   64'(bus.ft601_data_out), rxq.size() == 0 ? 64'd0 : 64'(rxq[0]));
    chk("be_out",     64'(bus.ft601_be_out),  64'hF);
    chk("din_ready",  64'(host_din_ready),    64'(ready));
    chk("dout_valid", 64'(host_dout_valid),   64'(txq.size() > 0));
    chk("dout",       64'(host_dout),         txq.size() == 0 ? 64'd0 : 64'(txq[0]));
    chk("err_wr_ovf", 64'(err_wr_ovf),        64'(m_ewr));
    chk("err_rd_udf", 64'(err_rd_udf),        64'(m_erd));
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_host) begin
      host_din_valid  = 1'($urandom_range(0, 1));
      host_din        = $urandom;
      host_dout_rd_en = ($urandom_range(0, 3) == 0);
    end
  endtask

  task automatic bus_idle();
    bus.ft601_oe_n = 1'b1;
    bus.ft601_rd_n = 1'b1;
    bus.ft601_wr_n = 1'b1;
  endtask

  task automatic push_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      host_din = base + 32'(i);
      host_din_valid = 1'b1;
      tick();
    end
    host_din_valid = 1'b0;
  endtask

  initial begin
    bus_idle();
    bus.ft601_siwu_n  = 1'b1;
    bus.ft601_data_in = '0;
    bus.ft601_be_in   = '0;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_rxf_n", 64'(bus.ft601_rxf_n), 64'd1);
    chk("rst_txe_n", 64'(bus.ft601_txe_n), 64'd0);
    chk("rst_data_oe", 64'(bus.ft601_data_oe), 64'd0);
    chk("rst_errs", {32'(err_wr_ovf), 32'(err_rd_udf)}, 64'd0);
    tick();
    rst_n = 1'b1;
    tick();

    // RX burst of 8
    push_words(32'h1000_0000, 8);
    bus.ft601_oe_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("rx_burst_word", 64'(bus.ft601_data_out), 64'(32'h1000_0000 + i));
      chk("rx_burst_oe", 64'(bus.ft601_data_oe), 64'd1);
      tick();
    end
    bus_idle();
    @(negedge clk);
    chk("rx_burst_rxf_n", 64'(bus.ft601_rxf_n), 64'd1);
    chk("rx_burst_udf", 64'(err_rd_udf), 64'd0);
    tick();

    // RX underflow
    bus.ft601_oe_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b0;
    repeat (3) tick();
    bus_idle();
    tick();
    @(negedge clk);
    chk("udf_count", 64'(err_rd_udf), 64'd3);
    chk("udf_data", 64'(bus.ft601_data_out), 64'd0);
    chk("udf_idle_oe", 64'(bus.ft601_data_oe), 64'd0);
    tick();

    // TX fill with host stalled
    for (int i = 0; i < 17; i++) begin
      bus.ft601_wr_n    = 1'b0;
      bus.ft601_data_in = 32'hA000_0000 + 32'(i);
      bus.ft601_be_in   = 4'(i);
      tick();
      @(negedge clk);
      if (i == 0)  chk("tx_first_valid", 64'(host_dout_valid), 64'd1);
      if (i == 11) chk("tx_txe_12", 64'(bus.ft601_txe_n), 64'd0);
      if (i == 12) chk("tx_txe_13", 64'(bus.ft601_txe_n), 64'd1);
      if (i == 16) chk("tx_ovf", 64'(err_wr_ovf), 64'd1);
    end
    bus_idle();
    tick();
    host_dout_rd_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("tx_pop_word", 64'(host_dout), 64'({4'(i), 32'hA000_0000 + 32'(i)}));
      tick();
    end
    host_dout_rd_en = 1'b0;
    @(negedge clk);
    chk("tx_empty", 64'(host_dout_valid), 64'd0);
    tick();

    // RX full with simultaneous host push and master read
    push_words(32'h2000_0000, 8);
    @(negedge clk);
    chk("full_ready", 64'(host_din_ready), 64'd0);
    bus.ft601_oe_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b0;
    for (int i = 0; i < 12; i++) begin
      host_din_valid = (i < 4);
      host_din = 32'h3000_0000 + 32'(i);
      @(negedge clk);
      chk("sim_word", 64'(bus.ft601_data_out),
          i < 8 ? 64'(32'h2000_0000 + i) : 64'(32'h3000_0000 + (i - 8)));
      if (i < 4) chk("sim_ready", 64'(host_din_ready), 64'd1);
      tick();
    end
    host_din_valid = 1'b0;
    bus_idle();
    tick();

    // Mid-burst reset
    push_words(32'h4000_0000, 8);
    bus.ft601_oe_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b0;
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_data_oe", 64'(bus.ft601_data_oe), 64'd0);
    chk("mrst_rxf_n", 64'(bus.ft601_rxf_n), 64'd1);
    bus_idle();
    tick();
    rst_n = 1'b1;
    tick();
    push_words(32'h5A5A_0001, 1);
    bus.ft601_oe_n = 1'b0;
    tick();
    bus.ft601_rd_n = 1'b0;
    @(negedge clk);
    chk("mrst_new_word", 64'(bus.ft601_data_out), 64'h5A5A_0001);
    tick();
    bus_idle();
    tick();

    // Randomized traffic, checked every cycle by the model
    rnd_host = 1;
    for (int it = 0; it < 300; it++) begin
      int op, len;
      op  = $urandom_range(0, 2);
      len = $urandom_range(1, 12);
      if (op == 1) begin
        bus.ft601_oe_n = 1'b0;
        tick();
        bus.ft601_rd_n = 1'b0;
        repeat (len) tick();
      end else if (op == 2) begin
        for (int k = 0; k < len + 8; k++) begin
          bus.ft601_wr_n    = 1'b0;
          bus.ft601_data_in = $urandom;
          bus.ft601_be_in   = 4'($urandom);
          tick();
        end
      end else begin
        repeat (len % 3 + 1) tick();
      end
      bus_idle();
      tick();
    end
    rnd_host = 0;
    host_din_valid = 1'b0;
    host_dout_rd_en = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
